// File: rtl/parity_frame_controller_if.sv
// Serial line and status bundle for parity_frame_controller.
// The master side drives the line and counter clear; the slave side is the controller.
interface parity_frame_controller_if #(
   parameter int DATA_BITS = 8,
   parameter int CNT_W     = 8
);
   logic                 in;
   logic                 clr_cnt;
   logic [2:0]           state;
   logic                 busy;
   logic                 frame_done;
   logic [DATA_BITS-1:0] data;
   logic                 parity_err;
   logic                 frame_err;
   logic [CNT_W-1:0]     frame_cnt;
   logic [CNT_W-1:0]     err_cnt;

   modport master (
      output in, clr_cnt,
      input  state, busy, frame_done, data, parity_err, frame_err, frame_cnt, err_cnt
   );

   modport slave (
      input  in, clr_cnt,
      output state, busy, frame_done, data, parity_err, frame_err, frame_cnt, err_cnt
   );
endinterface

// File: rtl/parity_frame_controller.sv
// Framed serial parity checker: start bit, DATA_BITS data bits LSB first, parity bit, stop bit.
// Reports one registered result per frame and keeps wrapping frame / saturating error counters.
module parity_frame_controller #(
   parameter int DATA_BITS = 8,
   parameter int ODD       = 0,
   parameter int CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   parity_frame_controller_if.slave bus
);
   localparam int             bw     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [bw-1:0]  last   = bw'(DATA_BITS - 1);
   localparam logic           oddbit = 1'(ODD);

   typedef enum logic [2:0] {
      HUNT   = 3'd0,
      IDLE   = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t               st;
   logic [bw-1:0]        bitcnt;
   logic                 acc;
   logic                 perr;
   logic [DATA_BITS-1:0] shreg;

   assign bus.state = st;

   // Framing FSM; a zero stop bit drops back to HUNT so an idle line must be seen again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st             <= HUNT;
         bitcnt         <= '0;
         acc            <= 1'b0;
         perr           <= 1'b0;
         shreg          <= '0;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.data       <= '0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.frame_cnt  <= '0;
         bus.err_cnt    <= '0;
      end else begin
         bus.frame_done <= 1'b0;
         case (st)
            HUNT: begin
               if (bus.in) st <= IDLE;
            end
            IDLE: begin
               if (!bus.in) begin
                  st       <= DATA;
                  bus.busy <= 1'b1;
                  bitcnt   <= '0;
                  acc      <= 1'b0;
               end
            end
            DATA: begin
               shreg[bitcnt] <= bus.in;
               acc           <= acc ^ bus.in;
               if (bitcnt == last) st <= PARITY;
               else                bitcnt <= bitcnt + 1'b1;
            end
            PARITY: begin
               perr <= ((acc ^ bus.in) != oddbit);
               st   <= STOP;
            end
            STOP: begin
               bus.frame_done <= 1'b1;
               bus.data       <= shreg;
               bus.parity_err <= perr;
               bus.frame_err  <= ~bus.in;
               bus.busy       <= 1'b0;
               st             <= bus.in ? IDLE : HUNT;
            end
            default: begin
               st       <= HUNT;
               bus.busy <= 1'b0;
            end
         endcase

         // A clear on the stop-bit edge wins over that frame's increment.
         if (bus.clr_cnt) begin
            bus.frame_cnt <= '0;
            bus.err_cnt   <= '0;
         end else if (st == STOP) begin
            bus.frame_cnt <= bus.frame_cnt + 1'b1;
            if ((perr || !bus.in) && (bus.err_cnt != '1))
               bus.err_cnt <= bus.err_cnt + 1'b1;
         end
      end
   end
endmodule
